// File: rtl/id_branch_resolve.sv
// ID-stage branch resolution: operand forwarding, hazard-driven stall sequencing
// and a saturating stall-cycle counter.
module id_branch_resolve (
    input  logic        clk,
    input  logic        rst,
    input  logic        Beq_ID,
    input  logic        Bne_ID,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        RegWriteEn_IDEX,
    input  logic        MemRead_IDEX,
    input  logic        Slt_IDEX,
    input  logic        Sgt_IDEX,
    input  logic [4:0]  writeRegister_IDEX,
    input  logic        MemRead_EXMEM,
    input  logic [4:0]  writeRegister_EXMEM,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] aluResult_EX,
    input  logic [31:0] aluResult_EXMEM,
    input  logic [31:0] writeData_MEMWB,
    output logic [31:0] operandA,
    output logic [31:0] operandB,
    output logic        stall_PC,
    output logic        stall_IFID,
    output logic        bubble_IDEX,
    output logic        branchTaken,
    output logic        flush_IFID,
    output logic [15:0] stallCount
);

    typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] need;
    logic       branch_id;
    logic       match_idex, match_exmem;
    logic       load_ex, alu_ex, load_mem;
    logic       stall, resolve, taken_eval;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] reg_data,
                                            input logic [31:0] memwb, input logic [31:0] exmem,
                                            input logic [31:0] ex);
        case (sel)
            2'b00:   return reg_data;
            2'b01:   return memwb;
            2'b10:   return exmem;
            default: return ex;
        endcase
    endfunction

    assign operandA = fwd_sel(ForwardA, readData1, writeData_MEMWB, aluResult_EXMEM, aluResult_EX);
    assign operandB = fwd_sel(ForwardB, readData2, writeData_MEMWB, aluResult_EXMEM, aluResult_EX);

    assign branch_id = Beq_ID | Bne_ID;

    // Register 0 is hardwired, so a match on it is never a hazard.
    assign match_idex  = ((rs != 5'd0) && (rs == writeRegister_IDEX)) ||
                         ((rt != 5'd0) && (rt == writeRegister_IDEX));
    assign match_exmem = ((rs != 5'd0) && (rs == writeRegister_EXMEM)) ||
                         ((rt != 5'd0) && (rt == writeRegister_EXMEM));

    // slt/sgt results are not usable by the ID comparator path, so they do not count as ALU hazards.
    assign load_ex  = match_idex & MemRead_IDEX;
    assign alu_ex   = match_idex & RegWriteEn_IDEX & ~MemRead_IDEX & ~(Slt_IDEX | Sgt_IDEX);
    assign load_mem = match_exmem & MemRead_EXMEM;
    assign need     = load_ex ? 2'd2 : ((alu_ex | load_mem) ? 2'd1 : 2'd0);

    // Beq wins when both decode lines are high.
    assign taken_eval = Beq_ID ? (operandA == operandB) :
                        Bne_ID ? (operandA != operandB) : 1'b0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        resolve   = 1'b0;
        case (state)
            IDLE: begin
                if (branch_id) begin
                    if (need == 2'd0) begin
                        resolve = 1'b1;
                    end else begin
                        stall = 1'b1;
                        if (need == 2'd2) begin
                            state_nxt = STALL;
                            cnt_nxt   = 2'd1;
                        end else begin
                            state_nxt = RESOLVE;
                        end
                    end
                end
            end
            STALL: begin
                stall     = 1'b1;
                state_nxt = RESOLVE;
                cnt_nxt   = 2'd0;
            end
            RESOLVE: begin
                resolve   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_PC    = stall;
    assign stall_IFID  = stall;
    assign bubble_IDEX = stall;
    assign branchTaken = resolve & taken_eval;
    assign flush_IFID  = branchTaken;

    // State / counter register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            stallCount <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall)
                stallCount <= sat_inc(stallCount);
        end
    end

endmodule

// File: tb/tb_id_branch_resolve.sv
// Directed bench for id_branch_resolve: expected outputs are queued as each
// vector is driven and compared once the combinational outputs settle.
module tb_id_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        Beq_ID, Bne_ID;
    logic [4:0]  rs, rt;
    logic        RegWriteEn_IDEX, MemRead_IDEX, Slt_IDEX, Sgt_IDEX;
    logic [4:0]  writeRegister_IDEX;
    logic        MemRead_EXMEM;
    logic [4:0]  writeRegister_EXMEM;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] readData1, readData2, aluResult_EX, aluResult_EXMEM, writeData_MEMWB;
    logic [31:0] operandA, operandB;
    logic        stall_PC, stall_IFID, bubble_IDEX, branchTaken, flush_IFID;
    logic [15:0] stallCount;

    typedef struct {
        logic        stall;
        logic        taken;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] sc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_sc;
    int          n_vec = 0;
    int          n_err = 0;

    id_branch_resolve dut (
        .clk(clk), .rst(rst), .Beq_ID(Beq_ID), .Bne_ID(Bne_ID), .rs(rs), .rt(rt),
        .RegWriteEn_IDEX(RegWriteEn_IDEX), .MemRead_IDEX(MemRead_IDEX),
        .Slt_IDEX(Slt_IDEX), .Sgt_IDEX(Sgt_IDEX), .writeRegister_IDEX(writeRegister_IDEX),
        .MemRead_EXMEM(MemRead_EXMEM), .writeRegister_EXMEM(writeRegister_EXMEM),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .readData1(readData1), .readData2(readData2),
        .aluResult_EX(aluResult_EX), .aluResult_EXMEM(aluResult_EXMEM),
        .writeData_MEMWB(writeData_MEMWB), .operandA(operandA), .operandB(operandB),
        .stall_PC(stall_PC), .stall_IFID(stall_IFID), .bubble_IDEX(bubble_IDEX),
        .branchTaken(branchTaken), .flush_IFID(flush_IFID), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        Beq_ID = 0; Bne_ID = 0; rs = 0; rt = 0;
        RegWriteEn_IDEX = 0; MemRead_IDEX = 0; Slt_IDEX = 0; Sgt_IDEX = 0;
        writeRegister_IDEX = 0; MemRead_EXMEM = 0; writeRegister_EXMEM = 0;
        ForwardA = 0; ForwardB = 0;
        readData1 = 0; readData2 = 0; aluResult_EX = 0; aluResult_EXMEM = 0; writeData_MEMWB = 0;
    endtask

    task automatic step(input string tag, input logic e_stall, input logic e_taken,
                        input logic [31:0] e_a, input logic [31:0] e_b);
        exp_t e;
        e.stall = e_stall; e.taken = e_taken; e.a = e_a; e.b = e_b; e.sc = exp_sc;
        sb.push_back(e);
        if (e_stall && exp_sc != 16'hFFFF)
            exp_sc = exp_sc + 16'd1;
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".stall_PC"},    32'(stall_PC),    32'(e.stall));
        chk({tag, ".stall_IFID"},  32'(stall_IFID),  32'(e.stall));
        chk({tag, ".bubble_IDEX"}, 32'(bubble_IDEX), 32'(e.stall));
        chk({tag, ".branchTaken"}, 32'(branchTaken), 32'(e.taken));
        chk({tag, ".flush_IFID"},  32'(flush_IFID),  32'(e.taken));
        chk({tag, ".operandA"},    operandA,         e.a);
        chk({tag, ".operandB"},    operandB,         e.b);
        chk({tag, ".stallCount"},  32'(stallCount),  32'(e.sc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; clr(); exp_sc = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        step("in_reset", 0, 0, 0, 0);
        rst = 0;
        step("idle", 0, 0, 0, 0);

        // beq, no hazard: same-cycle resolve
        clr(); Beq_ID = 1; rs = 3; rt = 3; readData1 = 5; readData2 = 5;
        step("beq_nohaz", 0, 1, 5, 5);

        // bne with load in ID/EX: two stalls, resolve with MEM/WB forward
        clr(); Bne_ID = 1; rs = 4; rt = 9; MemRead_IDEX = 1; writeRegister_IDEX = 4;
        readData1 = 1; readData2 = 7;
        step("bne_ld_s1", 1, 0, 1, 7);
        step("bne_ld_s2", 1, 0, 1, 7);
        ForwardA = 2'b01; writeData_MEMWB = 7;
        step("bne_ld_res", 0, 0, 7, 7);
        clr();
        step("bne_ld_after", 0, 0, 0, 0);

        // load in EX/MEM: one stall, bne taken
        clr(); Bne_ID = 1; rs = 8; MemRead_EXMEM = 1; writeRegister_EXMEM = 8;
        readData1 = 1; readData2 = 2;
        step("ldmem_s1", 1, 0, 1, 2);
        step("ldmem_res", 0, 1, 1, 2);

        // ALU producer on rt: one stall, then EX/MEM forward; hazard inputs stay high in RESOLVE
        clr(); Beq_ID = 1; rs = 2; rt = 6; RegWriteEn_IDEX = 1; writeRegister_IDEX = 6;
        readData1 = 10; readData2 = 99; aluResult_EXMEM = 10; aluResult_EX = 55; writeData_MEMWB = 77;
        step("alu_s1", 1, 0, 10, 99);
        ForwardB = 2'b10;
        step("alu_res", 0, 1, 10, 10);
        Slt_IDEX = 1; ForwardB = 2'b11; aluResult_EX = 10; aluResult_EXMEM = 33;
        step("slt_nostall", 0, 1, 10, 10);
        Slt_IDEX = 0; Sgt_IDEX = 1; aluResult_EX = 11;
        step("sgt_nostall", 0, 0, 10, 11);

        // forwarding mux coverage on non-branch cycles
        clr(); readData1 = 1; writeData_MEMWB = 2; aluResult_EXMEM = 3; aluResult_EX = 4; readData2 = 5;
        ForwardA = 2'b10; ForwardB = 2'b01;
        step("mux_a10_b01", 0, 0, 3, 2);
        ForwardA = 2'b11; ForwardB = 2'b00;
        step("mux_a11_b00", 0, 0, 4, 5);

        // register 0 never hazards; non-branch never stalls or takes
        clr(); Beq_ID = 1; MemRead_IDEX = 1; writeRegister_IDEX = 0; readData1 = 3; readData2 = 4;
        step("r0_nohaz", 0, 0, 3, 4);
        clr(); rs = 5; MemRead_IDEX = 1; writeRegister_IDEX = 5; readData1 = 6; readData2 = 6;
        step("nonbranch", 0, 0, 6, 6);

        // Beq priority over Bne
        clr(); Beq_ID = 1; Bne_ID = 1; rs = 1; rt = 2; readData1 = 9; readData2 = 9;
        step("beq_prio", 0, 1, 9, 9);

        // load in ID/EX and EX/MEM both match: need is the maximum (2)
        clr(); Beq_ID = 1; rs = 7; rt = 7; MemRead_IDEX = 1; writeRegister_IDEX = 7;
        MemRead_EXMEM = 1; writeRegister_EXMEM = 7; readData1 = 4; readData2 = 4;
        step("maxneed_s1", 1, 0, 4, 4);
        step("maxneed_s2", 1, 0, 4, 4);
        step("maxneed_res", 0, 1, 4, 4);

        // reset in STALL aborts the sequence
        clr(); Bne_ID = 1; rs = 1; rt = 12; MemRead_IDEX = 1; writeRegister_IDEX = 12;
        readData1 = 2; readData2 = 3;
        step("rst_s1", 1, 0, 2, 3);
        rst = 1;
        step("rst_in_stall", 1, 0, 2, 3);
        exp_sc = 16'd0;
        rst = 0; clr();
        step("rst_after", 0, 0, 0, 0);

        // saturation: preload near the top, then keep stalling
        force dut.stallCount = 16'hFFFD;
        #1;
        release dut.stallCount;
        exp_sc = 16'hFFFD;
        clr(); Bne_ID = 1; rs = 4; MemRead_IDEX = 1; writeRegister_IDEX = 4; readData1 = 1; readData2 = 1;
        for (int i = 0; i < 3; i++) begin
            step("sat_s1", 1, 0, 1, 1);
            step("sat_s2", 1, 0, 1, 1);
            step("sat_res", 0, 0, 1, 1);
        end
        clr();
        step("sat_final", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
